// File: rtl/ucsbece154b_victim_pkg.sv
`default_nettype none
// ============================================================================
// Module : ucsbece154b_victim_pkg
// Brief  : Shared FSM state encoding and default widths for the victim ctrl.
// Rev    : 1.0
// ============================================================================
package ucsbece154b_victim_pkg;

    localparam int unsigned c_DEF_ADDR_WIDTH = 56;
    localparam int unsigned c_DEF_LINE_WIDTH = 128;
    localparam int unsigned c_DEF_CNT_WIDTH  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROBE   = 3'd1,
        ST_MEMREQ  = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_RESP    = 3'd4,
        ST_FLUSH   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : ucsbece154b_sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
module ucsbece154b_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_victim_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ucsbece154b_victim_ctrl
// Brief  : L1 miss controller: probes an external victim cache, falls back
//          to memory, and services deferred victim-cache flushes.
// Rev    : 1.0
// ============================================================================
module ucsbece154b_victim_ctrl
    import ucsbece154b_victim_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = c_DEF_LINE_WIDTH,
    parameter int unsigned CNT_WIDTH  = c_DEF_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  evict_valid_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    input  logic [LINE_WIDTH-1:0] evict_data_i,
    output logic                  resp_valid_o,
    output logic [LINE_WIDTH-1:0] resp_data_o,
    output logic                  resp_vc_hit_o,
    input  logic                  flush_i,
    output logic                  vc_en_o,
    output logic                  vc_flush_o,
    output logic [ADDR_WIDTH-1:0] vc_raddr_o,
    input  logic [LINE_WIDTH-1:0] vc_rdata_i,
    input  logic                  vc_hit_i,
    output logic                  vc_we_o,
    output logic [ADDR_WIDTH-1:0] vc_waddr_o,
    output logic [LINE_WIDTH-1:0] vc_wdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_resp_data_i,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_flush_pending;
    logic [ADDR_WIDTH-1:0] r_miss_addr;
    logic                  r_evict_valid;
    logic [ADDR_WIDTH-1:0] r_evict_addr;
    logic [LINE_WIDTH-1:0] r_evict_data;
    logic [LINE_WIDTH-1:0] r_line;
    logic                  r_vc_hit;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_hit_inc;
    logic                  w_miss_inc;

    // A same-cycle flush_i also blocks acceptance so flush wins over a miss.
    assign w_ready    = rst_ni && (r_state == ST_IDLE) && !r_flush_pending && !flush_i;
    assign w_accept   = miss_valid_i && w_ready;
    assign w_hit_inc  = (r_state == ST_PROBE) && vc_hit_i;
    assign w_miss_inc = (r_state == ST_PROBE) && !vc_hit_i;

    assign miss_ready_o = w_ready;
    assign vc_en_o      = rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        vc_raddr_o      = '0;
        vc_we_o         = 1'b0;
        vc_waddr_o      = '0;
        vc_wdata_o      = '0;
        vc_flush_o      = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        resp_valid_o    = 1'b0;
        resp_data_o     = '0;
        resp_vc_hit_o   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_flush_pending) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_accept) begin
                    w_state_nxt = ST_PROBE;
                end
            end
            ST_PROBE: begin
                vc_raddr_o  = r_miss_addr;
                vc_we_o     = r_evict_valid;
                vc_waddr_o  = r_evict_addr;
                vc_wdata_o  = r_evict_data;
                w_state_nxt = vc_hit_i ? ST_RESP : ST_MEMREQ;
            end
            ST_MEMREQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = r_miss_addr;
                if (mem_req_ready_i) begin
                    w_state_nxt = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (mem_resp_valid_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_o  = 1'b1;
                resp_data_o   = r_line;
                resp_vc_hit_o = r_vc_hit;
                w_state_nxt   = ST_IDLE;
            end
            ST_FLUSH: begin
                vc_flush_o  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A flush arriving during FLUSH re-arms rather than being lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flush_pending <= 1'b0;
        end else begin
            r_flush_pending <= (r_flush_pending && (r_state != ST_FLUSH)) || flush_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss_addr   <= '0;
            r_evict_valid <= 1'b0;
            r_evict_addr  <= '0;
            r_evict_data  <= '0;
        end else if ((r_state == ST_IDLE) && !r_flush_pending && w_accept) begin
            r_miss_addr   <= miss_addr_i;
            r_evict_valid <= evict_valid_i;
            r_evict_addr  <= evict_addr_i;
            r_evict_data  <= evict_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_line   <= '0;
            r_vc_hit <= 1'b0;
        end else if (r_state == ST_PROBE) begin
            r_vc_hit <= vc_hit_i;
            if (vc_hit_i) begin
                r_line <= vc_rdata_i;
            end
        end else if ((r_state == ST_MEMWAIT) && mem_resp_valid_i) begin
            r_line <= mem_resp_data_i;
        end
    end

    ucsbece154b_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_hit_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_hit_inc),
        .cnt_o  (hit_cnt_o)
    );

    ucsbece154b_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_miss_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_miss_inc),
        .cnt_o  (miss_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_victim_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ucsbece154b_victim_ctrl
// Brief  : Directed + randomized bench with a victim-cache/memory environment
//          and a transaction-level reference of cache contents and counters.
// Rev    : 1.0
// ============================================================================
module tb_ucsbece154b_victim_ctrl;

    localparam int AW   = 56;
    localparam int LW   = 128;
    localparam int CW   = 4;
    localparam int VC_N = 64;

    logic          clk_i;
    logic          rst_ni;
    logic          miss_valid_i;
    logic          miss_ready_o;
    logic [AW-1:0] miss_addr_i;
    logic          evict_valid_i;
    logic [AW-1:0] evict_addr_i;
    logic [LW-1:0] evict_data_i;
    logic          resp_valid_o;
    logic [LW-1:0] resp_data_o;
    logic          resp_vc_hit_o;
    logic          flush_i;
    logic          vc_en_o;
    logic          vc_flush_o;
    logic [AW-1:0] vc_raddr_o;
    logic [LW-1:0] vc_rdata_i;
    logic          vc_hit_i;
    logic          vc_we_o;
    logic [AW-1:0] vc_waddr_o;
    logic [LW-1:0] vc_wdata_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [AW-1:0] mem_req_addr_o;
    logic          mem_resp_valid_i;
    logic [LW-1:0] mem_resp_data_i;
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] miss_cnt_o;

    int checks   = 0;
    int failures = 0;
    int ref_hits = 0;
    int ref_miss = 0;
    logic [LW-1:0] ref_line [logic [AW-1:0]];

    ucsbece154b_victim_ctrl #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .miss_valid_i     (miss_valid_i),
        .miss_ready_o     (miss_ready_o),
        .miss_addr_i      (miss_addr_i),
        .evict_valid_i    (evict_valid_i),
        .evict_addr_i     (evict_addr_i),
        .evict_data_i     (evict_data_i),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .resp_vc_hit_o    (resp_vc_hit_o),
        .flush_i          (flush_i),
        .vc_en_o          (vc_en_o),
        .vc_flush_o       (vc_flush_o),
        .vc_raddr_o       (vc_raddr_o),
        .vc_rdata_i       (vc_rdata_i),
        .vc_hit_i         (vc_hit_i),
        .vc_we_o          (vc_we_o),
        .vc_waddr_o       (vc_waddr_o),
        .vc_wdata_o       (vc_wdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // External victim cache: fully associative, combinational read.
    logic [AW-1:0] vc_tag [VC_N];
    logic [LW-1:0] vc_dat [VC_N];
    logic          vc_val [VC_N] = '{default: 1'b0};
    int            vc_cnt = 0;
    int            vc_slot;

    always_comb begin
        vc_hit_i   = 1'b0;
        vc_rdata_i = '0;
        for (int i = 0; i < VC_N; i++) begin
            if (vc_val[i] && (vc_tag[i] == vc_raddr_o)) begin
                vc_hit_i   = 1'b1;
                vc_rdata_i = vc_dat[i];
            end
        end
    end

    always @(posedge clk_i) begin
        if (vc_flush_o) begin
            for (int i = 0; i < VC_N; i++) vc_val[i] <= 1'b0;
            vc_cnt <= 0;
        end else if (vc_we_o) begin
            vc_slot = vc_cnt;
            for (int i = 0; i < VC_N; i++) begin
                if (vc_val[i] && (vc_tag[i] == vc_waddr_o)) vc_slot = i;
            end
            if (vc_slot < VC_N) begin
                vc_tag[vc_slot] <= vc_waddr_o;
                vc_dat[vc_slot] <= vc_wdata_o;
                vc_val[vc_slot] <= 1'b1;
                if (vc_slot == vc_cnt) vc_cnt <= vc_cnt + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] mem_pat(input logic [AW-1:0] a);
        return {8'h5A, a, 8'hC3, ~a};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        ref_hits = 0;
        ref_miss = 0;
        #1;
    endtask

    task automatic do_txn(input logic [AW-1:0] a, input logic ev, input logic [AW-1:0] ea,
                          input logic [LW-1:0] ed, input logic [LW-1:0] md,
                          input int rdy_dly, input int rsp_dly, input bit fl);
        logic          exp_hit;
        logic [LW-1:0] exp_data;
        int            n;
        exp_hit  = ref_line.exists(a);
        exp_data = exp_hit ? ref_line[a] : md;
        if (fl && rsp_dly == 0) rsp_dly = 1;
        n = 0;
        while (!miss_ready_o && n < 10) begin
            step();
            n++;
        end
        chk("idle_ready", miss_ready_o, 1);
        miss_valid_i  = 1'b1;
        miss_addr_i   = a;
        evict_valid_i = ev;
        evict_addr_i  = ea;
        evict_data_i  = ed;
        step();
        chk("probe_raddr", vc_raddr_o, a);
        chk("probe_we", vc_we_o, ev);
        if (ev) begin
            chk("probe_waddr", vc_waddr_o, ea);
            chk("probe_wdata", vc_wdata_o, ed);
        end
        chk("probe_no_resp", resp_valid_o, 0);
        miss_valid_i  = 1'b0;
        evict_valid_i = 1'b0;
        miss_addr_i   = '0;
        evict_addr_i  = '0;
        evict_data_i  = '0;
        if (exp_hit) begin
            step();
        end else begin
            step();
            for (int i = 0; i < rdy_dly; i++) begin
                chk("memreq_valid_hold", mem_req_valid_o, 1);
                chk("memreq_addr_hold", mem_req_addr_o, a);
                step();
            end
            chk("memreq_valid", mem_req_valid_o, 1);
            chk("memreq_addr", mem_req_addr_o, a);
            mem_req_ready_i = 1'b1;
            step();
            mem_req_ready_i = 1'b0;
            chk("memwait_no_req", mem_req_valid_o, 0);
            for (int i = 0; i < rsp_dly; i++) begin
                if (fl && i == 0) flush_i = 1'b1;
                step();
                flush_i = 1'b0;
                chk("memwait_no_flush", vc_flush_o, 0);
                chk("memwait_no_resp", resp_valid_o, 0);
            end
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = md;
            step();
            mem_resp_valid_i = 1'b0;
            mem_resp_data_i  = '0;
        end
        chk("resp_valid", resp_valid_o, 1);
        chk("resp_data", resp_data_o, exp_data);
        chk("resp_vc_hit", resp_vc_hit_o, exp_hit);
        if (exp_hit) ref_hits = (ref_hits < 15) ? ref_hits + 1 : 15;
        else         ref_miss = (ref_miss < 15) ? ref_miss + 1 : 15;
        if (ev) ref_line[ea] = ed;
        step();
        chk("resp_one_cycle", resp_valid_o, 0);
        chk("hit_cnt", hit_cnt_o, ref_hits);
        chk("miss_cnt", miss_cnt_o, ref_miss);
        if (fl && !exp_hit) begin
            chk("flush_idle_ready", miss_ready_o, 0);
            chk("flush_not_yet", vc_flush_o, 0);
            step();
            chk("flush_pulse", vc_flush_o, 1);
            chk("flush_ready", miss_ready_o, 0);
            ref_line.delete();
            step();
            chk("flush_done", vc_flush_o, 0);
            chk("flush_after_ready", miss_ready_o, 1);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] ea;
        rst_ni           = 1'b0;
        miss_valid_i     = 1'b0;
        miss_addr_i      = '0;
        evict_valid_i    = 1'b0;
        evict_addr_i     = '0;
        evict_data_i     = '0;
        flush_i          = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", miss_ready_o, 0);
        chk("rst_vc_en", vc_en_o, 0);
        chk("rst_resp", resp_valid_o, 0);
        chk("rst_memreq", mem_req_valid_o, 0);
        chk("rst_flush", vc_flush_o, 0);
        chk("rst_we", vc_we_o, 0);
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
        rst_ni = 1'b1;
        #1;
        chk("rel_ready", miss_ready_o, 1);
        chk("rel_vc_en", vc_en_o, 1);

        // Preload line 0x40 through an eviction, then hit it.
        do_txn(56'h200, 1'b1, 56'h40, {16{8'hAA}}, mem_pat(56'h200), 0, 1, 1'b0);
        do_txn(56'h40, 1'b0, '0, '0, mem_pat(56'h40), 0, 0, 1'b0);
        chk("hit_cnt_one", hit_cnt_o, 1);

        do_reset();
        do_txn(56'h80, 1'b1, 56'h100, {16{8'h3C}}, {16{8'h55}}, 3, 2, 1'b0);
        chk("miss_cnt_one", miss_cnt_o, 1);

        // Flush during MEMWAIT is deferred past RESP.
        do_txn(56'h140, 1'b0, '0, '0, mem_pat(56'h140), 1, 3, 1'b1);

        // Reset in MEMWAIT, then a stale memory response.
        miss_valid_i = 1'b1;
        miss_addr_i  = 56'h1000;
        step();
        miss_valid_i = 1'b0;
        step();
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst_resp", resp_valid_o, 0);
        chk("midrst_miss_cnt", miss_cnt_o, 0);
        step();
        rst_ni   = 1'b1;
        ref_hits = 0;
        ref_miss = 0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = {16{8'hEE}};
        step();
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        chk("stale_no_resp", resp_valid_o, 0);
        chk("stale_ready", miss_ready_o, 1);
        step();
        chk("stale_no_resp2", resp_valid_o, 0);
        chk("stale_hit_cnt", hit_cnt_o, 0);
        chk("stale_miss_cnt", miss_cnt_o, 0);

        for (int t = 0; t < 30; t++) begin
            a  = AW'($urandom_range(0, 15) * 64);
            ea = AW'($urandom_range(0, 15) * 64);
            if (ea == a) ea = ea ^ 56'h40;
            do_txn(a, 1'($urandom_range(0, 1)), ea, {$urandom, $urandom, $urandom, $urandom},
                   mem_pat(a), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 5) == 0));
        end

        do_reset();
        do_txn(56'h2000, 1'b1, 56'h40, {16{8'hAA}}, mem_pat(56'h2000), 0, 0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            do_txn(56'h40, 1'b0, '0, '0, mem_pat(56'h40), 0, 0, 1'b0);
        end
        chk("hit_cnt_saturated", hit_cnt_o, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
